// File: rtl/cricket_pkg.sv
// rtl/cricket_pkg.sv - shared state encoding, widths and default limits for the score engine
package cricket_pkg;

  typedef enum logic [1:0] {
    ST_INN1  = 2'd0,
    ST_BREAK = 2'd1,
    ST_INN2  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam int RUNS_W          = 8;
  localparam int WKT_W           = 4;
  localparam int BALL_W          = 6;
  localparam int TGT_W           = RUNS_W + 1;
  localparam int DEF_MAX_BALLS   = 12;
  localparam int DEF_MAX_WICKETS = 10;

endpackage

// File: rtl/cricket_score_engine_accum.sv
// rtl/cricket_score_engine_accum.sv - runs/wickets/balls counters with look-ahead next values
module score_accumulator
  import cricket_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              accept,
  input  logic [2:0]        ball_runs,
  input  logic              ball_wicket,
  input  logic              ball_extra,
  output logic [RUNS_W-1:0] runs,
  output logic [WKT_W-1:0]  wickets,
  output logic [BALL_W-1:0] balls,
  output logic [RUNS_W-1:0] runs_next,
  output logic [WKT_W-1:0]  wickets_next,
  output logic [BALL_W-1:0] balls_next
);

  logic [RUNS_W-1:0] runs_q, runs_d;
  logic [WKT_W-1:0]  wickets_q, wickets_d;
  logic [BALL_W-1:0] balls_q, balls_d;
  logic [RUNS_W:0]   runs_sum;

  // The *_next values assume the current delivery is applied; the parent gates them with accept.
  always_comb begin
    runs_sum     = {1'b0, runs_q} + {6'd0, ball_runs} + {{RUNS_W{1'b0}}, ball_extra};
    runs_next    = runs_sum[RUNS_W] ? {RUNS_W{1'b1}} : runs_sum[RUNS_W-1:0];
    wickets_next = wickets_q + {{(WKT_W-1){1'b0}}, ball_wicket};
    balls_next   = balls_q + {{(BALL_W-1){1'b0}}, ~ball_extra};

    runs_d    = runs_q;
    wickets_d = wickets_q;
    balls_d   = balls_q;
    if (clear) begin
      runs_d    = '0;
      wickets_d = '0;
      balls_d   = '0;
    end else if (accept) begin
      runs_d    = runs_next;
      wickets_d = wickets_next;
      balls_d   = balls_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      runs_q    <= '0;
      wickets_q <= '0;
      balls_q   <= '0;
    end else begin
      runs_q    <= runs_d;
      wickets_q <= wickets_d;
      balls_q   <= balls_d;
    end
  end

  assign runs    = runs_q;
  assign wickets = wickets_q;
  assign balls   = balls_q;

endmodule

// File: rtl/cricket_score_engine.sv
// rtl/cricket_score_engine.sv - two-innings match sequencer feeding the seven-segment display stage
module cricket_score_engine
  import cricket_pkg::*;
#(
  parameter int MAX_BALLS   = DEF_MAX_BALLS,
  parameter int MAX_WICKETS = DEF_MAX_WICKETS
) (
  input  logic              clk_fpga,
  input  logic              reset,
  input  logic              ball_strobe,
  input  logic [2:0]        ball_runs,
  input  logic              ball_wicket,
  input  logic              ball_extra,
  input  logic              advance,
  output logic [RUNS_W-1:0] binaryRuns,
  output logic [WKT_W-1:0]  binaryWickets,
  output logic [BALL_W-1:0] ballsBowled,
  output logic              inningOver,
  output logic              gameOver,
  output logic              winner
);

  state_e            state_q, state_d;
  logic [TGT_W-1:0]  target_q, target_d;
  logic              winner_q, winner_d;
  logic              inning_over_q, inning_over_d;
  logic              game_over_q, game_over_d;
  logic              accept, clear, innings_end;
  logic [RUNS_W-1:0] runs_next;
  logic [WKT_W-1:0]  wickets_next;
  logic [BALL_W-1:0] balls_next;

  score_accumulator u_accum (
    .clk          (clk_fpga),
    .reset        (reset),
    .clear        (clear),
    .accept       (accept),
    .ball_runs    (ball_runs),
    .ball_wicket  (ball_wicket),
    .ball_extra   (ball_extra),
    .runs         (binaryRuns),
    .wickets      (binaryWickets),
    .balls        (ballsBowled),
    .runs_next    (runs_next),
    .wickets_next (wickets_next),
    .balls_next   (balls_next)
  );

  assign innings_end = (wickets_next == WKT_W'(MAX_WICKETS)) ||
                       (balls_next == BALL_W'(MAX_BALLS));

  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    winner_d = winner_q;
    accept   = 1'b0;
    clear    = 1'b0;
    case (state_q)
      ST_INN1: begin
        if (ball_strobe) begin
          accept = 1'b1;
          if (innings_end) begin
            state_d  = ST_BREAK;
            target_d = {1'b0, runs_next} + TGT_W'(1);
          end
        end
      end
      ST_BREAK: begin
        if (advance) begin
          clear   = 1'b1;
          state_d = ST_INN2;
        end
      end
      ST_INN2: begin
        if (ball_strobe) begin
          accept = 1'b1;
          // Reaching the target wins outright, even on the innings-ending delivery.
          if ({1'b0, runs_next} >= target_q) begin
            state_d  = ST_DONE;
            winner_d = 1'b1;
          end else if (innings_end) begin
            state_d  = ST_DONE;
            winner_d = 1'b0;
          end
        end
      end
      default: ;
    endcase
    inning_over_d = (state_d == ST_BREAK);
    game_over_d   = (state_d == ST_DONE);
  end

  always_ff @(posedge clk_fpga) begin
    if (reset) begin
      state_q       <= ST_INN1;
      target_q      <= '0;
      winner_q      <= 1'b0;
      inning_over_q <= 1'b0;
      game_over_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      target_q      <= target_d;
      winner_q      <= winner_d;
      inning_over_q <= inning_over_d;
      game_over_q   <= game_over_d;
    end
  end

  assign inningOver = inning_over_q;
  assign gameOver   = game_over_q;
  assign winner     = winner_q;

endmodule

// File: tb/tb_cricket_score_engine.sv
// tb/tb_cricket_score_engine.sv - directed self-checking bench for cricket_score_engine
module tb_cricket_score_engine;

  logic       clk_fpga = 1'b0;
  logic       reset = 1'b1;
  logic       ball_strobe = 1'b0;
  logic [2:0] ball_runs = 3'd0;
  logic       ball_wicket = 1'b0;
  logic       ball_extra = 1'b0;
  logic       advance = 1'b0;
  logic [7:0] binaryRuns;
  logic [3:0] binaryWickets;
  logic [5:0] ballsBowled;
  logic       inningOver;
  logic       gameOver;
  logic       winner;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk_fpga = ~clk_fpga;

  cricket_score_engine dut (
    .clk_fpga      (clk_fpga),
    .reset         (reset),
    .ball_strobe   (ball_strobe),
    .ball_runs     (ball_runs),
    .ball_wicket   (ball_wicket),
    .ball_extra    (ball_extra),
    .advance       (advance),
    .binaryRuns    (binaryRuns),
    .binaryWickets (binaryWickets),
    .ballsBowled   (ballsBowled),
    .inningOver    (inningOver),
    .gameOver      (gameOver),
    .winner        (winner)
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input int r, input int w, input int b,
                           input int io, input int go, input int win);
    check({tag, ".runs"}, int'(binaryRuns), r);
    check({tag, ".wkts"}, int'(binaryWickets), w);
    check({tag, ".balls"}, int'(ballsBowled), b);
    check({tag, ".inningOver"}, int'(inningOver), io);
    check({tag, ".gameOver"}, int'(gameOver), go);
    check({tag, ".winner"}, int'(winner), win);
  endtask

  task automatic bowl(input logic [2:0] r, input logic w, input logic e);
    @(negedge clk_fpga);
    ball_runs = r; ball_wicket = w; ball_extra = e; ball_strobe = 1'b1;
    @(posedge clk_fpga); #1;
    ball_strobe = 1'b0; ball_runs = 3'd0; ball_wicket = 1'b0; ball_extra = 1'b0;
  endtask

  task automatic pulse_advance();
    @(negedge clk_fpga);
    advance = 1'b1;
    @(posedge clk_fpga); #1;
    advance = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk_fpga);
    reset = 1'b1;
    @(posedge clk_fpga); #1;
    reset = 1'b0;
  endtask

  // Five fours then seven dots: 20 runs over 12 legal balls.
  task automatic innings_of_20();
    for (int i = 0; i < 5; i++) bowl(3'd4, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) bowl(3'd0, 1'b0, 1'b0);
  endtask

  initial begin
    do_reset();
    check_all("reset", 0, 0, 0, 0, 0, 0);

    // 12 singles end innings 1; a further strobe is ignored.
    for (int i = 0; i < 11; i++) bowl(3'd1, 1'b0, 1'b0);
    check_all("inn1_11", 11, 0, 11, 0, 0, 0);
    bowl(3'd1, 1'b0, 1'b0);
    check_all("inn1_12", 12, 0, 12, 1, 0, 0);
    bowl(3'd3, 1'b1, 1'b0);
    check_all("break_strobe", 12, 0, 12, 1, 0, 0);

    // Extras: penalty run, no legal ball; wicket on a wide; advance ignored in INN1.
    do_reset();
    bowl(3'd0, 1'b0, 1'b1);
    check_all("wide0", 1, 0, 0, 0, 0, 0);
    bowl(3'd4, 1'b0, 1'b1);
    check_all("wide4", 6, 0, 0, 0, 0, 0);
    bowl(3'd0, 1'b1, 1'b1);
    check_all("wide_wkt", 7, 1, 0, 0, 0, 0);
    pulse_advance();
    check_all("adv_inn1", 7, 1, 0, 0, 0, 0);

    // All out after 10 wickets, then advance clears.
    do_reset();
    for (int i = 0; i < 9; i++) bowl(3'd0, 1'b1, 1'b0);
    check_all("wkt9", 0, 9, 9, 0, 0, 0);
    bowl(3'd0, 1'b1, 1'b0);
    check_all("wkt10", 0, 10, 10, 1, 0, 0);
    pulse_advance();
    check_all("adv_break", 0, 0, 0, 0, 0, 0);

    // Chase of 21: strobe with advance in BREAK is dropped; 21st run wins.
    do_reset();
    innings_of_20();
    check_all("chase_inn1", 20, 0, 12, 1, 0, 0);
    @(negedge clk_fpga);
    advance = 1'b1; ball_strobe = 1'b1; ball_runs = 3'd5;
    @(posedge clk_fpga); #1;
    advance = 1'b0; ball_strobe = 1'b0; ball_runs = 3'd0;
    check_all("adv_and_strobe", 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) bowl(3'd4, 1'b0, 1'b0);
    check_all("chase_20", 20, 0, 5, 0, 0, 0);
    bowl(3'd1, 1'b0, 1'b0);
    check_all("chase_win", 21, 0, 6, 0, 1, 1);
    bowl(3'd6, 1'b1, 1'b0);
    pulse_advance();
    check_all("done_frozen", 21, 0, 6, 0, 1, 1);

    // Tie on the last ball goes to team 1.
    do_reset();
    innings_of_20();
    pulse_advance();
    for (int i = 0; i < 5; i++) bowl(3'd4, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) bowl(3'd0, 1'b0, 1'b0);
    check_all("tie_11", 20, 0, 11, 0, 0, 0);
    bowl(3'd0, 1'b0, 1'b0);
    check_all("tie_done", 20, 0, 12, 0, 1, 0);

    // Target reached on the innings-ending ball still wins for team 2.
    do_reset();
    innings_of_20();
    pulse_advance();
    for (int i = 0; i < 11; i++) bowl(3'd0, 1'b0, 1'b0);
    bowl(3'd7, 1'b1, 1'b0);
    check_all("lastball_short", 7, 1, 12, 0, 1, 0);
    do_reset();
    innings_of_20();
    pulse_advance();
    for (int i = 0; i < 3; i++) bowl(3'd5, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) bowl(3'd0, 1'b0, 1'b0);
    bowl(3'd6, 1'b0, 1'b0);
    check_all("lastball_win", 21, 0, 12, 0, 1, 1);

    // Saturation at 255, then reset dominates a simultaneous strobe.
    do_reset();
    for (int i = 0; i < 50; i++) bowl(3'd6, 1'b0, 1'b1);
    check_all("saturate", 255, 0, 0, 0, 0, 0);
    @(negedge clk_fpga);
    reset = 1'b1; ball_strobe = 1'b1; ball_runs = 3'd6; ball_wicket = 1'b1;
    @(posedge clk_fpga); #1;
    reset = 1'b0; ball_strobe = 1'b0; ball_runs = 3'd0; ball_wicket = 1'b0;
    check_all("reset_strobe", 0, 0, 0, 0, 0, 0);
    bowl(3'd2, 1'b0, 1'b0);
    check_all("post_reset", 2, 0, 1, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/cricket_score_engine.md
# cricket_score_engine

Scoring engine that sits directly upstream of the seven-segment display stage. It consumes debounced one-cycle delivery events from the input/button logic and maintains the batting score: runs, wickets and legal balls. It sequences two innings and a chase, then produces the `binaryRuns`, `binaryWickets`, `inningOver`, `gameOver` and `winner` signals that the display stage renders.

## Interface
Parameters:
- `MAX_BALLS`, default 12: legal balls per innings (2 overs); range 1–63.
- `MAX_WICKETS`, default 10: wickets ending an innings; range 1–15.

Ports:
- `clk_fpga` in 1: master clock, 100 MHz. Single clock domain.
- `reset` in 1: synchronous, active-high.
- `ball_strobe` in 1: one-cycle pulse; one delivery completed.
- `ball_runs` in 3: runs scored off the delivery, 0–7. Sampled only with `ball_strobe`.
- `ball_wicket` in 1: delivery took a wicket. Sampled only with `ball_strobe`.
- `ball_extra` in 1: wide or no-ball. Adds 1 penalty run; not a legal ball. Sampled only with `ball_strobe`.
- `advance` in 1: one-cycle pulse; starts innings 2 from the break.
- `binaryRuns` out 8: current innings runs, saturating at 255.
- `binaryWickets` out 4: current innings wickets.
- `ballsBowled` out 6: legal balls in the current innings.
- `inningOver` out 1: high only in BREAK.
- `gameOver` out 1: high only in DONE.
- `winner` out 1: 0 means team 1, 1 means team 2. Valid only while `gameOver` is high; held at 0 otherwise.

## Operation
- States:
  - INN1: team 1 bats.
  - BREAK: innings 1 is complete.
  - INN2: team 2 chases.
  - DONE: result locked.
- Reset puts the block in INN1. All outputs go to 0, and the target goes to 0.
- Delivery accepted only in INN1 or INN2 with `ball_strobe`=1. Strobes in BREAK or DONE are ignored.
- Per accepted delivery:
  - `runs_next = sat255(runs + ball_runs + ball_extra)`.
  - Wickets increment if `ball_wicket`=1.
  - Balls increment if `ball_extra`=0.
  - A wicket on an extra counts as a wicket but not as a ball.
- The innings ends on the delivery that makes `wickets_next == MAX_WICKETS` or `balls_next == MAX_BALLS`.
- INN1 to BREAK on end of innings:
  - `target` latches `runs_next + 1` as 9 bits, so 255 becomes 256.
  - Outputs keep showing the final innings-1 score.
- BREAK to INN2 on `advance`:
  - runs, wickets and balls clear to 0.
  - `target` is held.
- `advance` in any state other than BREAK is ignored.
- INN2 to DONE, checked in this priority order:
  1. `{1'b0, runs_next} >= target`: `winner`=1. This takes precedence even if the same delivery ends the innings.
  2. End of innings otherwise: `winner`=0. A tie also gives `winner`=0.
- DONE: outputs frozen until `reset`.
- Wickets and balls never exceed their limits, because the innings ends at the limit.

## Timing
- All outputs are registered.
- `ball_strobe` sampled at edge N: counters, state and flags are visible after edge N. This is 1-cycle latency.
- `inningOver`, `gameOver` and `winner` change on the same edge as the deciding delivery's counters.
- `advance` at edge N: zeroed counters and `inningOver`=0 are visible after edge N.
- `reset` dominates every other input on the same edge, including mid-innings and in DONE.
- Back-to-back strobes on consecutive cycles are each accepted.
- A strobe on the edge that enters BREAK or DONE is that deciding delivery. A strobe on the next cycle is ignored.
- `ball_strobe` and `advance` on the same edge: in BREAK `advance` wins and the strobe is dropped; elsewhere the strobe is processed and `advance` is dropped.

## Structure
- Shared package `cricket_pkg`:
  - state encoding INN1/BREAK/INN2/DONE, 2 bits;
  - width constants RUNS_W=8, WKT_W=4, BALL_W=6;
  - default limits.
- Sub-module `score_accumulator`:
  - saturating runs adder, wicket counter and ball counter;
  - synchronous clear;
  - combinational `*_next` outputs, used by the parent FSM for limit and target checks.
- Parent module holds the FSM, the target register and the winner register.

## Test plan
- Reset, then innings 1 of 12 legal balls with `ball_runs`=1. Expect `binaryRuns`=12 and `ballsBowled`=12, with `inningOver`=1 one cycle after the 12th strobe. A further strobe changes nothing.
- INN1 with a wide (`ball_extra`=1, runs=0), then a 4-run wide. Expect runs=1 then 6, `ballsBowled` stays 0. Wicket on a wide: wickets=1, balls=0.
- INN1: 10 strobes with `ball_wicket`=1. Expect BREAK after the 10th with `binaryWickets`=10. Then `advance`: all counters 0, `inningOver`=0.
- Innings 1 ends with 20 runs, so target=21. In INN2, deliveries totalling 21 are followed by `gameOver`=1 and `winner`=1 on the next cycle; a later strobe is ignored.
- Tie: innings 1 = 20, innings 2 = 20 after 12 balls. Expect `gameOver`=1 and `winner`=0.
- Saturation and reset: 50 strobes of 6 runs with `ball_extra`=1 give `binaryRuns`=255. Assert `reset` together with a strobe: all outputs 0 and state INN1.
